// File: rtl/odometer_scan_master.sv
// Scan master for a daisy chain of odometers: shifts a control word, triggers a measurement, reads counts back.
// Defining ODOMETER_SAT_DETECT_EN adds the SAT flag for saturated (10'h3FF) counts; otherwise SAT is tied low.
module odometer_scan_master #(
  parameter int N_ODO     = 1,
  parameter int SCK_HALF  = 2,
  parameter int MEAS_WAIT = 4096
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       START,
  input  logic       ABORT,
  input  logic [6:0] CTRL_WORD,
  input  logic       SCAN_OUT_INT,
  output logic       SCAN_IN,
  output logic       SCAN_CLK1,
  output logic       LOAD,
  output logic       MEAS_TRIG,
  output logic       SCAN_CLK2,
  output logic       SCANCHAIN_IN,
  output logic [9:0] DATA_OUT,
  output logic [7:0] ODO_IDX,
  output logic       DATA_VALID,
  output logic       SAT,
  output logic       BUSY,
  output logic       DONE
);

  localparam int PW = $clog2(2 * SCK_HALF);
  localparam int WW = $clog2(MEAS_WAIT + 1);
  localparam logic [PW-1:0] PH_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [PW-1:0] PH_HI    = PW'(SCK_HALF);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * SCK_HALF - 1);
  localparam logic [WW-1:0] W_ZERO   = {WW{1'b0}};
  localparam logic [WW-1:0] W_ONE    = WW'(1);
  localparam logic [WW-1:0] W_LAST   = WW'(MEAS_WAIT - 1);
  localparam logic [7:0]    GRP_LAST = 8'(N_ODO - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_SHIFT = 3'd1,
    CFG_LOAD  = 3'd2,
    TRIG      = 3'd3,
    WAIT_MEAS = 3'd4,
    READ      = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    grp_q, grp_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [6:0]    ctrl_q, ctrl_d;
  logic [9:0]    sr_q, sr_d;
  logic          scan_in_q, scan_in_d;
  logic          sck1_q, sck1_d;
  logic          load_q, load_d;
  logic          trig_q, trig_d;
  logic          sck2_q, sck2_d;
  logic [9:0]    data_q, data_d;
  logic [7:0]    idx_q, idx_d;
  logic          dv_q, dv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ph_last, grp_last;
`ifdef ODOMETER_SAT_DETECT_EN
  logic          sat_q, sat_d;
`endif

  assign ph_last  = (ph_q == PH_LAST);
  assign grp_last = (grp_q == GRP_LAST);

  // State, counters and registered outputs
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= IDLE;
      ph_q      <= PH_ZERO;
      bit_q     <= 4'd0;
      grp_q     <= 8'd0;
      wcnt_q    <= W_ZERO;
      ctrl_q    <= 7'd0;
      sr_q      <= 10'd0;
      scan_in_q <= 1'b0;
      sck1_q    <= 1'b0;
      load_q    <= 1'b0;
      trig_q    <= 1'b0;
      sck2_q    <= 1'b0;
      data_q    <= 10'd0;
      idx_q     <= 8'd0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ODOMETER_SAT_DETECT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      grp_q     <= grp_d;
      wcnt_q    <= wcnt_d;
      ctrl_q    <= ctrl_d;
      sr_q      <= sr_d;
      scan_in_q <= scan_in_d;
      sck1_q    <= sck1_d;
      load_q    <= load_d;
      trig_q    <= trig_d;
      sck2_q    <= sck2_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ODOMETER_SAT_DETECT_EN
      sat_q     <= sat_d;
`endif
    end
  end

  // Next state and counters; bit 11 of the last READ frame is a one-cycle drain slot
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    grp_d   = grp_q;
    wcnt_d  = wcnt_q;
    ctrl_d  = ctrl_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d = CFG_SHIFT;
          ctrl_d  = CTRL_WORD;
          ph_d    = PH_ZERO;
          bit_d   = 4'd0;
          grp_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CFG_SHIFT: begin
        if (ph_last) begin
          ph_d = PH_ZERO;
          if (bit_q == 4'd6) begin
            bit_d = 4'd0;
            if (grp_last) begin
              grp_d   = 8'd0;
              state_d = CFG_LOAD;
            end else begin
              grp_d = grp_q + 8'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      CFG_LOAD: begin
        if (ph_last) begin
          ph_d    = PH_ZERO;
          state_d = TRIG;
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      TRIG: begin
        if (ph_last) begin
          ph_d    = PH_ZERO;
          wcnt_d  = W_ZERO;
          state_d = WAIT_MEAS;
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      WAIT_MEAS: begin
        if (wcnt_q == W_LAST) begin
          wcnt_d  = W_ZERO;
          ph_d    = PH_ZERO;
          bit_d   = 4'd0;
          grp_d   = 8'd0;
          state_d = READ;
        end else begin
          wcnt_d = wcnt_q + W_ONE;
        end
      end
      READ: begin
        if (bit_q == 4'd11) begin
          bit_d   = 4'd0;
          grp_d   = 8'd0;
          state_d = FINISH;
        end else if (ph_last) begin
          ph_d = PH_ZERO;
          if (bit_q == 4'd10) begin
            if (grp_last) begin
              bit_d = 4'd11;
            end else begin
              bit_d = 4'd0;
              grp_d = grp_q + 8'd1;
            end
          end else begin
            sr_d[bit_q] = SCAN_OUT_INT;
            bit_d       = bit_q + 4'd1;
          end
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ABORT && (state_q != IDLE)) begin
      state_d = IDLE;
      ph_d    = PH_ZERO;
      bit_d   = 4'd0;
      grp_d   = 8'd0;
      wcnt_d  = W_ZERO;
    end else begin
      state_d = state_d;
    end
  end

  // Outputs decoded from the next state so the registered pins line up with the state register
  always_comb begin
    scan_in_d = 1'b0;
    sck1_d    = 1'b0;
    load_d    = 1'b0;
    trig_d    = 1'b0;
    sck2_d    = 1'b0;
    case (state_d)
      CFG_SHIFT: begin
        sck1_d    = (ph_d >= PH_HI);
        scan_in_d = ctrl_d[3'd6 - bit_d[2:0]];
      end
      CFG_LOAD: begin
        load_d = (ph_d >= PH_HI);
      end
      TRIG: begin
        trig_d = 1'b1;
      end
      READ: begin
        sck2_d = (ph_d >= PH_HI) && (bit_d != 4'd11);
      end
      default: begin
        sck1_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
    dv_d   = 1'b0;
    data_d = data_q;
    idx_d  = idx_q;
    if ((state_q == READ) && ph_last && (bit_q == 4'd10) && !ABORT) begin
      dv_d   = 1'b1;
      data_d = sr_q;
      idx_d  = grp_q;
    end else begin
      dv_d = 1'b0;
    end
`ifdef ODOMETER_SAT_DETECT_EN
    sat_d = dv_d && (data_d == 10'h3FF);
`endif
  end

  assign SCAN_IN      = scan_in_q;
  assign SCAN_CLK1    = sck1_q;
  assign LOAD         = load_q;
  assign MEAS_TRIG    = trig_q;
  assign SCAN_CLK2    = sck2_q;
  assign SCANCHAIN_IN = 1'b0;
  assign DATA_OUT     = data_q;
  assign ODO_IDX      = idx_q;
  assign DATA_VALID   = dv_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
`ifdef ODOMETER_SAT_DETECT_EN
  assign SAT          = sat_q;
`else
  assign SAT          = 1'b0;
`endif

endmodule

// File: tb/tb_odometer_scan_master.sv
// Randomized self-checking bench for odometer_scan_master with a behavioural odometer chain and event monitors.
module tb_odometer_scan_master;
  localparam int N_ODO     = 2;
  localparam int SCK_HALF  = 2;
  localparam int MEAS_WAIT = 24;
  localparam int SEQ_LEN   = (7 * N_ODO + 2 + 11 * N_ODO) * 2 * SCK_HALF + MEAS_WAIT + 2;
  localparam int LIMIT     = 4 * SEQ_LEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] ctrl_word = 7'd0;
  logic       scan_out_int;
  logic       scan_in, scan_clk1, load, meas_trig, scan_clk2, scanchain_in;
  logic [9:0] data_out;
  logic [7:0] odo_idx;
  logic       data_valid, sat, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  odometer_scan_master #(.N_ODO(N_ODO), .SCK_HALF(SCK_HALF), .MEAS_WAIT(MEAS_WAIT)) dut (
    .CLK(clk), .RESETB(rst_n), .START(start), .ABORT(abort), .CTRL_WORD(ctrl_word),
    .SCAN_OUT_INT(scan_out_int), .SCAN_IN(scan_in), .SCAN_CLK1(scan_clk1), .LOAD(load),
    .MEAS_TRIG(meas_trig), .SCAN_CLK2(scan_clk2), .SCANCHAIN_IN(scanchain_in),
    .DATA_OUT(data_out), .ODO_IDX(odo_idx), .DATA_VALID(data_valid), .SAT(sat),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Odometer chain model: presents the next serial bit after each falling readout clock
  logic [63:0] stream_v = 64'd0;
  int clk2_falls = 0;
  int rd_base = 0;
  always @(negedge scan_clk2) clk2_falls++;
  assign scan_out_int = stream_v[6'(clk2_falls - rd_base)];

  int cyc = 0, clk1_rises = 0, load_rises = 0, trig_rises = 0, trig_cycles = 0;
  int clk2_rises = 0, done_cycles = 0, busy_cycles = 0, last_done_cyc = 0;
  logic        sin_q[$];
  logic [18:0] dv_q[$];
  int          dv_cyc[$];
  logic p_clk1 = 1'b0, p_load = 1'b0, p_trig = 1'b0, p_clk2 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (scan_clk1 && !p_clk1) begin clk1_rises++; sin_q.push_back(scan_in); end
    if (load && !p_load) load_rises++;
    if (meas_trig && !p_trig) trig_rises++;
    if (meas_trig) trig_cycles++;
    if (scan_clk2 && !p_clk2) clk2_rises++;
    if (data_valid) begin dv_q.push_back({sat, odo_idx, data_out}); dv_cyc.push_back(cyc); end
    if (done) begin done_cycles++; last_done_cyc = cyc; end
    if (busy) busy_cycles++;
    p_clk1 = scan_clk1; p_load = load; p_trig = meas_trig; p_clk2 = scan_clk2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] all_outs();
    return {scan_in, scan_clk1, load, meas_trig, scan_clk2, scanchain_in,
            data_out, odo_idx, data_valid, sat, busy, done};
  endfunction

  function automatic logic exp_sat(input logic [9:0] c);
`ifdef ODOMETER_SAT_DETECT_EN
    return (c == 10'h3FF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_chain(input logic [9:0] c0, input logic [9:0] c1);
    logic [9:0] c;
    stream_v = 64'd0;
    for (int k = 0; k < N_ODO; k++) begin
      c = (k == 0) ? c0 : c1;
      for (int b = 0; b < 10; b++) stream_v[k * 11 + b] = c[b];
      stream_v[k * 11 + 10] = 1'($urandom_range(1, 0));
    end
    rd_base = clk2_falls;
  endtask

  // Full sequence against the reference: bit order, pulse counts, frames, DONE timing and length
  task automatic run_seq(input logic [6:0] ctrl, input logic [9:0] c0, input logic [9:0] c1, input bit poke);
    int s_clk1, s_load, s_trigr, s_trigc, s_clk2, s_done, s_busy, s_sin, s_dv, t;
    logic [13:0] got_bits, exp_bits;
    logic [9:0]  c;
    logic [18:0] got;
    load_chain(c0, c1);
    s_clk1 = clk1_rises; s_load = load_rises; s_trigr = trig_rises; s_trigc = trig_cycles;
    s_clk2 = clk2_rises; s_done = done_cycles; s_busy = busy_cycles;
    s_sin = sin_q.size(); s_dv = dv_q.size();
    @(negedge clk); ctrl_word = ctrl; start = 1'b1;
    @(negedge clk); start = 1'b0; ctrl_word = 7'($urandom);
    if (poke) begin
      repeat (5) @(negedge clk);
      start = 1'b1; ctrl_word = ~ctrl;
      @(negedge clk); start = 1'b0;
    end
    t = 0;
    while (done_cycles == s_done && t < LIMIT) begin @(negedge clk); t++; end
    check_eq("done_timeout", (t < LIMIT) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("clk1_pulses", clk1_rises - s_clk1, 7 * N_ODO);
    got_bits = 14'd0; exp_bits = 14'd0;
    for (int i = 0; i < 7 * N_ODO; i++) begin
      got_bits[i] = (s_sin + i < sin_q.size()) ? sin_q[s_sin + i] : 1'bx;
      exp_bits[i] = ctrl[6 - (i % 7)];
    end
    check_eq("scan_in_bits", got_bits, exp_bits);
    check_eq("load_pulses", load_rises - s_load, 1);
    check_eq("trig_pulses", trig_rises - s_trigr, 1);
    check_eq("trig_cycles", trig_cycles - s_trigc, 2 * SCK_HALF);
    check_eq("clk2_pulses", clk2_rises - s_clk2, 11 * N_ODO);
    check_eq("dv_count", dv_q.size() - s_dv, N_ODO);
    for (int k = 0; k < N_ODO; k++) begin
      c = (k == 0) ? c0 : c1;
      got = (s_dv + k < dv_q.size()) ? dv_q[s_dv + k] : 19'h7FFFF;
      check_eq("frame", got, {exp_sat(c), 8'(k), c});
    end
    check_eq("done_cycles", done_cycles - s_done, 1);
    check_eq("done_after_dv", last_done_cyc - ((dv_cyc.size() > 0) ? dv_cyc[dv_cyc.size() - 1] : 0), 1);
    check_eq("seq_length", busy_cycles - s_busy, SEQ_LEN);
    check_eq("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int s_busy, s_clk2, s_dv, s_done, s_trig, t;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", all_outs(), 28'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_outs", all_outs(), 28'd0);

    run_seq(7'b1010011, 10'h155, 10'h2AA, 1'b1);
    for (int r = 0; r < 4; r++)
      run_seq(7'($urandom), 10'($urandom), (r == 2) ? 10'h3FF : 10'($urandom), 1'b0);

    // START together with ABORT in IDLE never leaves IDLE
    s_busy = busy_cycles;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("start_abort_idle", busy_cycles - s_busy, 0);

    // ABORT during the measurement wait
    load_chain(10'h0F0, 10'h00F);
    s_clk2 = clk2_rises; s_dv = dv_q.size(); s_done = done_cycles; s_trig = trig_rises;
    @(negedge clk); ctrl_word = 7'h55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while ((trig_rises == s_trig || meas_trig) && t < LIMIT) begin @(negedge clk); t++; end
    check_eq("trig_timeout", (t < LIMIT) ? 32'd1 : 32'd0, 32'd1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_eq("abort_outs", all_outs() & 28'hFC0000F, 28'd0);
    repeat (11 * N_ODO * 2 * SCK_HALF + MEAS_WAIT + 10) @(negedge clk);
    check_eq("abort_clk2", clk2_rises - s_clk2, 0);
    check_eq("abort_dv", dv_q.size() - s_dv, 0);
    check_eq("abort_done", done_cycles - s_done, 0);

    // Reset pulse in READ bit 5, then a clean sequence
    load_chain(10'h3C3, 10'h1A5);
    s_clk2 = clk2_rises; s_done = done_cycles;
    @(negedge clk); ctrl_word = 7'h2B; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (clk2_rises - s_clk2 < 6 && t < LIMIT) begin @(negedge clk); t++; end
    check_eq("read5_timeout", (t < LIMIT) ? 32'd1 : 32'd0, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outs", all_outs(), 28'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_no_done", done_cycles - s_done, 0);
    run_seq(7'h4E, 10'h2D2, 10'h12D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
